servo_position_ctrl: RTL



---
 rtl/servo_position_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/servo_position_ctrl.sv
// Supervised servo move sequencer: slews speed_cmd toward a target angle from feedback samples,
// detects settling and enforces a RUN timeout. Optional interrupt logic under SERVO_CTRL_IRQ_EN.
module servo_position_ctrl #(
  parameter int NEUTRAL      = 1500,
  parameter int MAX_DELTA    = 500,
  parameter int TOL          = 2,
  parameter int HOLD_SAMPLES = 4
) (
  input  logic        clock_clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic        cs,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] angle,
  input  logic        angle_valid,
  output logic [31:0] speed_cmd,
  output logic        irq
);

  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam logic signed [33:0] MAX_S = 34'(MAX_DELTA);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FAULT = 2'd3} state_t;

  state_t             state_q, state_d;
  logic        [31:0] target_sh_q, target_q, target_d;
  logic        [31:0] step_q, timeout_q, angle_q;
  logic signed [31:0] offset_q, offset_d;
  logic        [31:0] speed_q, speed_d;
  logic        [HW-1:0] hold_q, hold_d, hold_inc;
  logic        [31:0] tcnt_q, tcnt_d, tcnt_inc;
  logic               done_q, done_d, fault_q, fault_d;
  logic               done_set, fault_set;
  logic        [31:0] readdata_q, rdata_mux;
  logic               irq_en_rd;

  logic               wr, rd, start, abort, clr_done, clr_fault;
  logic        [31:0] step_eff;
  logic signed [32:0] err;
  logic        [32:0] abs_err;
  logic               in_tol;
  logic signed [33:0] off_ext, step_ext, up, dn, toward0, toward_tgt;

  assign wr        = cs & write;
  assign rd        = cs & read;
  assign start     = wr && (address == 3'd0) && writedata[0];
  assign abort     = wr && (address == 3'd0) && writedata[1];
  assign clr_done  = wr && (address == 3'd4) && writedata[2];
  assign clr_fault = wr && (address == 3'd4) && writedata[3];

  // Slew arithmetic is done 34 bits wide so a huge STEP cannot wrap past the clamp.
  assign step_eff = (step_q == 32'd0) ? 32'd1 : step_q;
  assign err      = $signed({target_q[31], target_q}) - $signed({angle[31], angle});
  assign abs_err  = err[32] ? (33'd0 - 33'(err)) : 33'(err);
  assign in_tol   = abs_err <= 33'(TOL);
  assign off_ext  = 34'(offset_q);
  assign step_ext = $signed({2'b00, step_eff});
  assign up       = off_ext + step_ext;
  assign dn       = off_ext - step_ext;
  assign hold_inc = hold_q + HW'(1);
  assign tcnt_inc = tcnt_q + 32'd1;

  always_comb begin
    toward0 = 34'sd0;
    if (off_ext > 34'sd0)      toward0 = (dn < 34'sd0) ? 34'sd0 : dn;
    else if (off_ext < 34'sd0) toward0 = (up > 34'sd0) ? 34'sd0 : up;
    if (!err[32]) toward_tgt = (up > MAX_S) ? MAX_S : up;
    else          toward_tgt = (dn < -MAX_S) ? -MAX_S : dn;
  end

  // Abort beats start, start (retarget) beats sampling, a settling sample beats the timeout.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    hold_d    = hold_q;
    tcnt_d    = tcnt_q;
    target_d  = target_q;
    done_set  = 1'b0;
    fault_set = 1'b0;
    case (state_q)
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          offset_d = '0;
        end else if (start) begin
          target_d = target_sh_q;
          hold_d   = '0;
          tcnt_d   = '0;
        end else begin
          tcnt_d = tcnt_inc;
          if (angle_valid) begin
            if (in_tol) begin
              hold_d   = hold_inc;
              offset_d = 32'(toward0);
            end else begin
              hold_d   = '0;
              offset_d = 32'(toward_tgt);
            end
          end
          if (angle_valid && in_tol && (hold_inc == HW'(HOLD_SAMPLES))) begin
            state_d  = DONE;
            offset_d = '0;
            hold_d   = '0;
            done_set = 1'b1;
          end else if ((timeout_q != 32'd0) && (tcnt_inc == timeout_q)) begin
            state_d   = FAULT;
            offset_d  = '0;
            fault_set = 1'b1;
          end
        end
      end
      default: begin
        if (start && !abort) begin
          state_d  = RUN;
          target_d = target_sh_q;
          hold_d   = '0;
          tcnt_d   = '0;
          offset_d = '0;
        end
      end
    endcase
  end

  assign speed_d = 32'(NEUTRAL) + offset_d;
  // A new event sets a sticky bit even if software clears it in the same cycle.
  assign done_d  = (done_q & ~clr_done) | done_set;
  assign fault_d = (fault_q & ~clr_fault) | fault_set;

  always_comb begin
    rdata_mux = 32'd0;
    case (address)
      3'd0: rdata_mux = {29'd0, irq_en_rd, 2'b00};
      3'd1: rdata_mux = target_sh_q;
      3'd2: rdata_mux = step_q;
      3'd3: rdata_mux = timeout_q;
      3'd4: rdata_mux = {28'd0, fault_q, done_q, state_q};
      3'd5: rdata_mux = angle_q;
      3'd6: rdata_mux = speed_q;
      default: rdata_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_sh_q <= '0;
      target_q    <= '0;
      step_q      <= 32'd10;
      timeout_q   <= 32'd50_000_000;
      angle_q     <= '0;
      offset_q    <= '0;
      speed_q     <= 32'(NEUTRAL);
      hold_q      <= '0;
      tcnt_q      <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      readdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      offset_q <= offset_d;
      speed_q  <= speed_d;
      hold_q   <= hold_d;
      tcnt_q   <= tcnt_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      if (angle_valid)              angle_q     <= angle;
      if (wr && address == 3'd1)    target_sh_q <= writedata;
      if (wr && address == 3'd2)    step_q      <= writedata;
      if (wr && address == 3'd3)    timeout_q   <= writedata;
      if (rd)                       readdata_q  <= rdata_mux;
    end
  end

`ifdef SERVO_CTRL_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clock_clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && address == 3'd0) irq_en_q <= writedata[2];
      irq_q <= irq_en_q & (done_q | fault_q);
    end
  end

  assign irq_en_rd = irq_en_q;
  assign irq       = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign irq       = 1'b0;
`endif

  assign readdata  = readdata_q;
  assign speed_cmd = speed_q;

endmodule
